// File: rtl/door_code_sender.sv
// door_code_sender: bit-serial code transmitter for the door lock controller.
// Parks the lock in reset while idle, shifts a parallel code out MSB first,
// waits for the lock's unlock/error response and tracks consecutive failures.
// Optional feature macro: DOOR_SENDER_LOCKOUT_EN enables the LOCKOUT state
// that blocks new attempts for LOCKOUT_CYC cycles after MAX_TRIES failures.
module door_code_sender #(
    parameter int unsigned CODE_W       = 4,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned LOCKOUT_CYC  = 64,
    parameter int unsigned RESP_TIMEOUT = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [CODE_W-1:0]                  code,
    output logic                               ready,
    output logic                               lock_reset,
    output logic                               out,
    input  logic                               unlock,
    input  logic                               error,
    output logic                               done,
    output logic                               granted,
    output logic                               denied,
    output logic                               timeout,
    output logic                               locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

    localparam int unsigned FAIL_W    = $clog2(MAX_TRIES + 1);
    localparam int unsigned CNT_TOP_A = (CODE_W > RESP_TIMEOUT) ? CODE_W : RESP_TIMEOUT;
    localparam int unsigned CNT_TOP   = (LOCKOUT_CYC > CNT_TOP_A) ? LOCKOUT_CYC : CNT_TOP_A;
    localparam int unsigned CNT_W     = $clog2(CNT_TOP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_GAP,
        S_SHIFT,
`ifdef DOOR_SENDER_LOCKOUT_EN
        S_WAIT,
        S_LOCKOUT
`else
        S_WAIT
`endif
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_fin;
    logic                r_ready;
    logic                r_lock_reset;
    logic                r_out;
    logic                r_done;
    logic                r_granted;
    logic                r_denied;
    logic                r_timeout;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic                w_fail_sat;

    assign w_fail_sat = (r_fail_cnt == FAIL_W'(MAX_TRIES));

    assign ready      = r_ready;
    assign lock_reset = r_lock_reset;
    assign out        = r_out;
    assign done       = r_done;
    assign granted    = r_granted;
    assign denied     = r_denied;
    assign timeout    = r_timeout;
    assign fail_cnt   = r_fail_cnt;

`ifdef DOOR_SENDER_LOCKOUT_EN
    logic r_locked_out;
    assign locked_out = r_locked_out;
`else
    assign locked_out = 1'b0;
`endif

    // Attempt sequencer: state, shift register, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_fin        <= 1'b0;
            r_ready      <= 1'b1;
            r_lock_reset <= 1'b1;
            r_out        <= 1'b0;
            r_done       <= 1'b0;
            r_granted    <= 1'b0;
            r_denied     <= 1'b0;
            r_timeout    <= 1'b0;
            r_fail_cnt   <= '0;
`ifdef DOOR_SENDER_LOCKOUT_EN
            r_locked_out <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_lock_reset <= 1'b1;
                    r_out        <= 1'b0;
                    if (start) begin
                        r_sr    <= code;
                        r_ready <= 1'b0;
                        r_state <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    r_lock_reset <= 1'b0;
                    r_out        <= 1'b0;
                    r_state      <= S_GAP;
                end

                S_GAP: begin
                    r_out   <= r_sr[CODE_W-1];
                    r_sr    <= r_sr << 1;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (r_cnt == CNT_W'(CODE_W - 1)) begin
                        r_out   <= 1'b0;
                        r_cnt   <= '0;
                        r_fin   <= 1'b0;
                        r_state <= S_WAIT;
                    end else begin
                        r_out <= r_sr[CODE_W-1];
                        r_sr  <= r_sr << 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    r_out <= 1'b0;
                    if (r_fin) begin
                        // done cycle: clear result flags and leave the attempt
                        r_fin     <= 1'b0;
                        r_done    <= 1'b0;
                        r_granted <= 1'b0;
                        r_denied  <= 1'b0;
                        r_timeout <= 1'b0;
`ifdef DOOR_SENDER_LOCKOUT_EN
                        if (w_fail_sat) begin
                            r_cnt        <= '0;
                            r_locked_out <= 1'b1;
                            r_state      <= S_LOCKOUT;
                        end else
`endif
                        begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (unlock || error) begin
                        // error dominates when both responses are raised
                        r_fin        <= 1'b1;
                        r_done       <= 1'b1;
                        r_lock_reset <= 1'b1;
                        r_granted    <= ~error;
                        r_denied     <= error;
                        if (!error) begin
                            r_fail_cnt <= '0;
                        end else if (!w_fail_sat) begin
                            r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
                        end
                    end else if (r_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                        r_fin        <= 1'b1;
                        r_done       <= 1'b1;
                        r_lock_reset <= 1'b1;
                        r_timeout    <= 1'b1;
                        if (!w_fail_sat) begin
                            r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

`ifdef DOOR_SENDER_LOCKOUT_EN
                S_LOCKOUT: begin
                    r_lock_reset <= 1'b1;
                    if (r_cnt == CNT_W'(LOCKOUT_CYC - 1)) begin
                        r_cnt        <= '0;
                        r_fail_cnt   <= '0;
                        r_locked_out <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif

                default: begin
                    r_ready      <= 1'b1;
                    r_lock_reset <= 1'b1;
                    r_out        <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_code_sender.sv
// Testbench for door_code_sender: drives attempts, plays the lock's response
// and checks results through a scoreboard of expected outcomes.
module tb_door_code_sender;

    localparam int CODE_W      = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCKOUT_CYC = 64;
    localparam logic [3:0] PASSWORD = 4'b1010;
`ifdef DOOR_SENDER_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int R_GRANT = 0;
    localparam int R_DENY  = 1;
    localparam int R_TOUT  = 2;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [CODE_W-1:0] code;
    logic              ready;
    logic              lock_reset;
    logic              out;
    logic              unlock;
    logic              error;
    logic              done;
    logic              granted;
    logic              denied;
    logic              timeout;
    logic              locked_out;
    logic [1:0]        fail_cnt;

    typedef struct {
        int res;
        int fail;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   mdl_fail;

    door_code_sender #(
        .CODE_W      (CODE_W),
        .MAX_TRIES   (MAX_TRIES),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .RESP_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .code       (code),
        .ready      (ready),
        .lock_reset (lock_reset),
        .out        (out),
        .unlock     (unlock),
        .error      (error),
        .done       (done),
        .granted    (granted),
        .denied     (denied),
        .timeout    (timeout),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Run one attempt starting at a negedge where ready=1.
    // mode 0: lock compares shifted bits, 1: unlock+error together, 2: silent lock.
    task automatic attempt(input logic [3:0] c, input int mode);
        logic [3:0] got;
        exp_t e;
        bit seen;
        seen = 1'b0;
        got  = '0;
        if (mode == 2)      e.res = R_TOUT;
        else if (mode == 1) e.res = R_DENY;
        else                e.res = (c == PASSWORD) ? R_GRANT : R_DENY;
        if (e.res == R_GRANT)         mdl_fail = 0;
        else if (mdl_fail < MAX_TRIES) mdl_fail++;
        e.fail = mdl_fail;
        e.cyc  = (e.res == R_TOUT) ? 22 : 10;
        sb.push_back(e);

        check_val("ready_before_start", ready, 1);
        code  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cy = 0; cy < 40; cy++) begin
            if (cy == 0) begin
                check_val("sync_lock_reset", lock_reset, 1);
                check_val("ready_low", ready, 0);
            end
            if (cy == 1) begin
                check_val("gap_lock_reset", lock_reset, 0);
                check_val("gap_out", out, 0);
            end
            if (cy >= 2 && cy <= 5) begin
                got[5-cy] = out;
                check_val("out_bit", out, c[5-cy]);
            end
            if (cy == 6) check_val("wait_out", out, 0);
            if (cy == 9 && mode != 2) begin
                unlock = (mode == 1) || (got == PASSWORD);
                error  = (mode == 1) || (got != PASSWORD);
            end
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check_val("done_cycle", cy, e.cyc);
                check_val("granted", granted, (e.res == R_GRANT) ? 1 : 0);
                check_val("denied",  denied,  (e.res == R_DENY)  ? 1 : 0);
                check_val("timeout", timeout, (e.res == R_TOUT)  ? 1 : 0);
                check_val("fail_cnt_done", fail_cnt, e.fail);
                break;
            end
            @(negedge clk);
        end
        unlock = 1'b0;
        error  = 1'b0;
        if (!seen) check_val("done_seen", 0, 1);
    endtask

    // From the done cycle: observe lockout (with start pushed), end at first IDLE cycle.
    task automatic post_attempt();
        int n;
        int rdy_hi;
        int exp_len;
        exp_len = (LOCK_EN && mdl_fail == MAX_TRIES) ? LOCKOUT_CYC : 0;
        @(negedge clk);
        check_val("done_pulse_len", done, 0);
        n      = 0;
        rdy_hi = 0;
        while (locked_out && n < 200) begin
            if (ready) rdy_hi++;
            start = (n < 20);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("lockout_len", n, exp_len);
        check_val("lockout_ready", rdy_hi, 0);
        if (exp_len != 0) mdl_fail = 0;
        check_val("ready_after", ready, 1);
        check_val("fail_cnt_after", fail_cnt, mdl_fail);
        check_val("locked_out_after", locked_out, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        mdl_fail = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        code     = '0;
        unlock   = 1'b0;
        error    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_lock_reset", lock_reset, 1);
        check_val("rst_out", out, 0);
        check_val("rst_done", done, 0);
        check_val("rst_locked_out", locked_out, 0);
        check_val("rst_fail_cnt", fail_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        attempt(4'b1010, 0); post_attempt();
        attempt(4'b0110, 0); post_attempt();
        attempt(4'b1010, 2); post_attempt();
        attempt(4'b1010, 0); post_attempt();
        attempt(4'b1010, 1); post_attempt();
        attempt(4'b1010, 0); post_attempt();
        attempt(4'b0001, 0); post_attempt();
        attempt(4'b1111, 0); post_attempt();
        attempt(4'b0110, 0); post_attempt();
        attempt(4'b0000, 0); post_attempt();

        // reset in the third SHIFT cycle
        code  = 4'b1010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_ready", ready, 1);
        check_val("mid_rst_lock_reset", lock_reset, 1);
        check_val("mid_rst_out", out, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_locked_out", locked_out, 0);
        check_val("mid_rst_fail_cnt", fail_cnt, 0);
        mdl_fail = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        attempt(4'b1010, 0); post_attempt();

        check_val("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/door_code_sender.md
# door_code_sender

Bit-serial code transmitter driving the password input of the door lock controller. It accepts a parallel code over a ready/start handshake and parks the lock in reset while idle. It releases the lock, shifts the code out MSB first in the lock's INPUT window, then waits for the lock's `unlock`/`error` response. It counts consecutive failures and, when compiled in, enforces a lockout period after too many failed attempts.

## Interface
- `CODE_W`, 4: code width; must match the lock's password width.
- `MAX_TRIES`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_CYC`, 64: lockout duration in clock cycles (≥1).
- `RESP_TIMEOUT`, 16: WAIT cycles allowed before a timeout is declared (≥8).
- `clk`  in  1  rising-edge clock shared with the lock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `code`  in  CODE_W  code to send; sampled on accept.
- `ready`  out  1  high only in IDLE.
- `lock_reset`  out  1  active-high reset to the lock.
- `out`  out  1  serial code bit to the lock's `in`.
- `unlock`  in  1  lock response, pass.
- `error`  in  1  lock response, fail.
- `done`  out  1  one-cycle pulse at the end of an attempt.
- `granted`, `denied`, `timeout`  out  1 each  result flags; valid only while `done`=1.
- `locked_out`  out  1  high during LOCKOUT.
- `fail_cnt`  out  $clog2(MAX_TRIES+1)  consecutive failure count.

## Operation
- States: IDLE, SYNC, GAP, SHIFT, WAIT, LOCKOUT. All outputs are registered.
- Reset values: state IDLE, `ready`=1, `lock_reset`=1, `out`=0, `done`/`granted`/`denied`/`timeout`/`locked_out`=0, `fail_cnt`=0, shift register 0.
- IDLE: `lock_reset`=1. On `start`, capture `code` into the shift register and go to SYNC. `start` is ignored in all other states.
- SYNC (1 cycle): `lock_reset`=1, `out`=0, then go to GAP.
- GAP (1 cycle): `lock_reset`=0, `out`=0. This is the lock's IDLE cycle.
- SHIFT (CODE_W cycles): `out` = code[CODE_W-1] down to code[0], one bit per cycle, then go to WAIT.
- WAIT: hold `out`=0 and count cycles.
  - `unlock`=1 and `error`=0: granted.
  - `error`=1, including when `unlock` is also 1: denied.
  - Count reaches RESP_TIMEOUT: timeout.
- End of attempt: pulse `done` with exactly one result flag set.
- Granted: clear `fail_cnt`.
- Denied or timeout: increment `fail_cnt`, saturating at MAX_TRIES.
- Next state after an attempt: LOCKOUT if `fail_cnt` reaches MAX_TRIES and lockout is compiled in; otherwise IDLE.
- LOCKOUT: `locked_out`=1, `lock_reset`=1, `ready`=0. Count LOCKOUT_CYC cycles, then clear `fail_cnt` and go to IDLE.
- Reset asserted mid-operation: immediate return to reset values. `lock_reset` goes to 1 asynchronously, forcing the lock back to IDLE.

## Timing
- Cycle 0 is the first SYNC cycle, one cycle after `start` is accepted.
- Cycle 1 is GAP. Cycles 2..CODE_W+1 carry the code bits. WAIT starts at cycle CODE_W+2.
- With CODE_W=4, the lock's response is visible in cycle 9, which is WAIT cycle 4. `done` is asserted in the cycle after the response is sampled.
- Minimum attempt length for a granted result, `start` accept to `done`: 11 cycles.
- `ready` falls in the cycle after accept and rises in the cycle after `done`, or after LOCKOUT expires.
- Back-to-back: `start` held high re-arms immediately in the first IDLE cycle.
- A response arriving in the same cycle the timeout count is reached wins over timeout.

## Configuration
- `DOOR_SENDER_LOCKOUT_EN` defined: failure counting and the LOCKOUT state behave as described above.
- Not defined: the LOCKOUT state and its counter are removed.
  - `locked_out` is tied to 0.
  - `fail_cnt` still counts and saturates, and is cleared on granted.
  - The block always returns to IDLE after `done`.

## Test plan
- Lock with PASSWORD=1010, send code 4'b1010: `out` = 1,0,1,0 in cycles 2–5; `done`+`granted` in cycle 10; `fail_cnt`=0.
- Send 4'b0110: `done`+`denied`; `fail_cnt`=1; `ready`=1 next cycle.
- Three wrong codes back-to-back with the macro defined: third `done` with `fail_cnt`=3; `locked_out`=1 for 64 cycles with `start` ignored; then `fail_cnt`=0 and `ready`=1. Without the macro: no lockout, `fail_cnt` stays 3.
- `unlock` and `error` tied low: `done`+`timeout` after 16 WAIT cycles; `fail_cnt` increments.
- Assert `reset_n` low during SHIFT cycle 3: all outputs return to reset values immediately and `lock_reset`=1; the next `start` with 1010 gives `granted`.
- Force `unlock`=1 and `error`=1 together in WAIT: result is `denied`, not `granted`.
